bus_arbiter: RTL and testbench

Two-master arbiter that shares the single 16-bit CPU memory bus between the `cpu` bus master (master 0) and a secondary master (master 1, e.g. DMA or debug port). It performs round-robin arbitration, forwards the granted master's request to the slave side, and routes `ack` back to that master only. A per-transfer watchdog terminates any transfer the slave never acknowledges.

---
 rtl/bus_arbiter.sv | 137 +++++++++++++
 tb/tb_bus_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared 16-bit CPU memory bus.
// The granted master's request passes straight through to the slave side,
// and ack/err are routed back to that master only. A per-transfer watchdog
// ends any transfer the slave never acknowledges.
module bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // master 0 (cpu)
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [15:0]           m0_wrdata,
  input  logic                  m0_cyc,
  input  logic                  m0_write,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [15:0]           m0_rddata,
  // master 1 (dma / debug)
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [15:0]           m1_wrdata,
  input  logic                  m1_cyc,
  input  logic                  m1_write,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [15:0]           m1_rddata,
  // slave side
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [15:0]           bus_wrdata,
  output logic                  bus_cyc,
  output logic                  bus_write,
  input  logic [15:0]           bus_rddata,
  input  logic                  bus_ack
);

  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q,  last_d;
  logic [TCNT_W-1:0]   tcnt_q,  tcnt_d;

  logic                  sel_cyc;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [15:0]           sel_wrdata;
  logic                  ack_c;
  logic                  err_c;

  // Request of whichever master currently holds the grant.
  assign sel_cyc    = grant_q ? m1_cyc    : m0_cyc;
  assign sel_write  = grant_q ? m1_write  : m0_write;
  assign sel_addr   = grant_q ? m1_addr   : m0_addr;
  assign sel_wrdata = grant_q ? m1_wrdata : m0_wrdata;

  // Read data is broadcast; only the matching ack makes it meaningful.
  assign m0_rddata = bus_rddata;
  assign m1_rddata = bus_rddata;

  // Completion / abort pulses go to the granted master only.
  assign m0_ack = ack_c & ~grant_q;
  assign m1_ack = ack_c &  grant_q;
  assign m0_err = err_c & ~grant_q;
  assign m1_err = err_c &  grant_q;

  // State, grant, fairness and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Arbitration, slave-side forwarding and transfer termination.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    tcnt_d     = tcnt_q;
    bus_cyc    = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = '0;
    bus_wrdata = '0;
    ack_c      = 1'b0;
    err_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_cyc || m1_cyc) begin
          state_d = ST_BUSY;
          tcnt_d  = '0;
          // On a tie the master that did not go last wins.
          if (m0_cyc && m1_cyc) grant_d = ~last_q;
          else                  grant_d = m1_cyc;
        end
      end

      ST_BUSY: begin
        bus_cyc    = sel_cyc;
        bus_write  = sel_write;
        bus_addr   = sel_addr;
        bus_wrdata = sel_wrdata;
        if (!sel_cyc) begin
          // Master withdrew: no response, fairness history untouched.
          state_d = ST_IDLE;
        end else if (bus_ack) begin
          // Ack beats a coincident timeout.
          ack_c   = 1'b1;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end else if (tcnt_q == TCNT_LAST) begin
          err_c   = 1'b1;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_bus_arbiter;

  localparam int unsigned AW = 14;
  localparam int          TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] m0_addr, m1_addr, bus_addr;
  logic [15:0]   m0_wrdata, m1_wrdata, bus_wrdata;
  logic          m0_cyc, m1_cyc, m0_write, m1_write;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic [15:0]   m0_rddata, m1_rddata, bus_rddata;
  logic          bus_cyc, bus_write, bus_ack;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_wrdata(m0_wrdata), .m0_cyc(m0_cyc), .m0_write(m0_write),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rddata(m0_rddata),
    .m1_addr(m1_addr), .m1_wrdata(m1_wrdata), .m1_cyc(m1_cyc), .m1_write(m1_write),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rddata(m1_rddata),
    .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_cyc(bus_cyc),
    .bus_write(bus_write), .bus_rddata(bus_rddata), .bus_ack(bus_ack)
  );

  typedef struct packed {
    logic          m0_cyc;
    logic          m0_write;
    logic [AW-1:0] m0_addr;
    logic [15:0]   m0_wrdata;
    logic          m1_cyc;
    logic          m1_write;
    logic [AW-1:0] m1_addr;
    logic [15:0]   m1_wrdata;
    logic          bus_ack;
    logic [15:0]   bus_rddata;
  } in_t;

  typedef struct packed {
    logic          bus_cyc;
    logic          bus_write;
    logic [AW-1:0] bus_addr;
    logic [15:0]   bus_wrdata;
    logic          m0_ack;
    logic          m0_err;
    logic          m1_ack;
    logic          m1_err;
    logic [15:0]   m0_rddata;
    logic [15:0]   m1_rddata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the bus, how many BUSY cycles it has used,
  // and who completed most recently (-1 owner = bus free).
  int mdl_owner;
  int mdl_used;
  int mdl_last;

  function automatic in_t ii(input logic c0, input logic w0, input logic [AW-1:0] a0,
                             input logic [15:0] d0, input logic c1, input logic w1,
                             input logic [AW-1:0] a1, input logic [15:0] d1,
                             input logic ack, input logic [15:0] rd);
    in_t v;
    v.m0_cyc = c0; v.m0_write = w0; v.m0_addr = a0; v.m0_wrdata = d0;
    v.m1_cyc = c1; v.m1_write = w1; v.m1_addr = a1; v.m1_wrdata = d1;
    v.bus_ack = ack; v.bus_rddata = rd;
    return v;
  endfunction

  function automatic out_t oo(input logic cyc, input logic w, input logic [AW-1:0] a,
                              input logic [15:0] d, input logic a0, input logic e0,
                              input logic a1, input logic e1, input logic [15:0] rd);
    out_t o;
    o.bus_cyc = cyc; o.bus_write = w; o.bus_addr = a; o.bus_wrdata = d;
    o.m0_ack = a0; o.m0_err = e0; o.m1_ack = a1; o.m1_err = e1;
    o.m0_rddata = rd; o.m1_rddata = rd;
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("cyc=%b we=%b addr=%h wd=%h ack0=%b err0=%b ack1=%b err1=%b rd0=%h rd1=%h",
                     o.bus_cyc, o.bus_write, o.bus_addr, o.bus_wrdata,
                     o.m0_ack, o.m0_err, o.m1_ack, o.m1_err, o.m0_rddata, o.m1_rddata);
  endfunction

  task automatic drive(input in_t v);
    m0_cyc = v.m0_cyc; m0_write = v.m0_write; m0_addr = v.m0_addr; m0_wrdata = v.m0_wrdata;
    m1_cyc = v.m1_cyc; m1_write = v.m1_write; m1_addr = v.m1_addr; m1_wrdata = v.m1_wrdata;
    bus_ack = v.bus_ack; bus_rddata = v.bus_rddata;
  endtask

  function automatic out_t sample();
    return {bus_cyc, bus_write, bus_addr, bus_wrdata, m0_ack, m0_err, m1_ack, m1_err,
            m0_rddata, m1_rddata};
  endfunction

  task automatic check(input string nm, input out_t got, input out_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got [%s] expected [%s]", nm, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic void mdl_reset();
    mdl_owner = -1;
    mdl_used  = 0;
    mdl_last  = 1;
  endfunction

  // Outputs the bus should show this cycle, given the inputs.
  function automatic out_t mdl_out(input in_t v);
    out_t o;
    logic owner_cyc;
    o = '0;
    o.m0_rddata = v.bus_rddata;
    o.m1_rddata = v.bus_rddata;
    if (mdl_owner >= 0) begin
      owner_cyc   = (mdl_owner == 1) ? v.m1_cyc : v.m0_cyc;
      o.bus_cyc   = owner_cyc;
      o.bus_write = (mdl_owner == 1) ? v.m1_write  : v.m0_write;
      o.bus_addr  = (mdl_owner == 1) ? v.m1_addr   : v.m0_addr;
      o.bus_wrdata = (mdl_owner == 1) ? v.m1_wrdata : v.m0_wrdata;
      if (owner_cyc) begin
        if (v.bus_ack) begin
          if (mdl_owner == 1) o.m1_ack = 1'b1; else o.m0_ack = 1'b1;
        end else if (mdl_used == TO - 1) begin
          if (mdl_owner == 1) o.m1_err = 1'b1; else o.m0_err = 1'b1;
        end
      end
    end
    return o;
  endfunction

  // Advance the model across one rising edge.
  function automatic void mdl_step(input in_t v);
    logic owner_cyc;
    if (mdl_owner < 0) begin
      mdl_used = 0;
      if (v.m0_cyc && v.m1_cyc) mdl_owner = 1 - mdl_last;
      else if (v.m0_cyc)        mdl_owner = 0;
      else if (v.m1_cyc)        mdl_owner = 1;
    end else begin
      owner_cyc = (mdl_owner == 1) ? v.m1_cyc : v.m0_cyc;
      if (!owner_cyc) begin
        mdl_owner = -1;
      end else if (v.bus_ack || mdl_used == TO - 1) begin
        mdl_last  = mdl_owner;
        mdl_owner = -1;
      end else begin
        mdl_used++;
      end
    end
  endfunction

  // One clock: apply inputs, sample mid-cycle, step the model at the edge.
  task automatic cycle(input in_t v, output out_t got, output out_t exp);
    drive(v);
    @(negedge clk);
    got = sample();
    exp = mdl_out(v);
    mdl_step(v);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  v;
    out_t got, exp;
    int   busy, errs, err_pos;
    int   order[$];
    logic r0, r1;

    // Directed table starting from reset: tie, single read, stray ack, max address.
    tbl[0]  = {ii(1,0,14'h0040,16'h0000, 1,1,14'h0200,16'h1234, 0,16'h0000),
               oo(0,0,14'h0000,16'h0000, 0,0,0,0, 16'h0000)};
    tbl[1]  = {ii(1,0,14'h0040,16'h0000, 1,1,14'h0200,16'h1234, 1,16'h0A0A),
               oo(1,0,14'h0040,16'h0000, 1,0,0,0, 16'h0A0A)};
    tbl[2]  = {ii(0,0,14'h0000,16'h0000, 1,1,14'h0200,16'h1234, 0,16'h0000),
               oo(0,0,14'h0000,16'h0000, 0,0,0,0, 16'h0000)};
    tbl[3]  = {ii(0,0,14'h0000,16'h0000, 1,1,14'h0200,16'h1234, 0,16'h0000),
               oo(1,1,14'h0200,16'h1234, 0,0,0,0, 16'h0000)};
    tbl[4]  = {ii(0,0,14'h0000,16'h0000, 1,1,14'h0200,16'h1234, 1,16'h0000),
               oo(1,1,14'h0200,16'h1234, 0,0,1,0, 16'h0000)};
    tbl[5]  = {ii(0,0,14'h0000,16'h0000, 0,0,14'h0000,16'h0000, 0,16'h0000),
               oo(0,0,14'h0000,16'h0000, 0,0,0,0, 16'h0000)};
    tbl[6]  = {ii(1,0,14'h0010,16'h0000, 0,0,14'h0000,16'h0000, 0,16'h0000),
               oo(0,0,14'h0000,16'h0000, 0,0,0,0, 16'h0000)};
    tbl[7]  = {ii(1,0,14'h0010,16'h0000, 0,0,14'h0000,16'h0000, 0,16'h0000),
               oo(1,0,14'h0010,16'h0000, 0,0,0,0, 16'h0000)};
    tbl[8]  = {ii(1,0,14'h0010,16'h0000, 0,0,14'h0000,16'h0000, 0,16'h0000),
               oo(1,0,14'h0010,16'h0000, 0,0,0,0, 16'h0000)};
    tbl[9]  = {ii(1,0,14'h0010,16'h0000, 0,0,14'h0000,16'h0000, 1,16'hBEEF),
               oo(1,0,14'h0010,16'h0000, 1,0,0,0, 16'hBEEF)};
    tbl[10] = {ii(0,0,14'h0000,16'h0000, 0,0,14'h0000,16'h0000, 1,16'h5555),
               oo(0,0,14'h0000,16'h0000, 0,0,0,0, 16'h5555)};
    tbl[11] = {ii(0,0,14'h0000,16'h0000, 0,0,14'h0000,16'h0000, 0,16'h0000),
               oo(0,0,14'h0000,16'h0000, 0,0,0,0, 16'h0000)};
    tbl[12] = {ii(0,0,14'h0000,16'h0000, 1,0,14'h3FFF,16'hFFFF, 0,16'h0000),
               oo(0,0,14'h0000,16'h0000, 0,0,0,0, 16'h0000)};
    tbl[13] = {ii(0,0,14'h0000,16'h0000, 1,0,14'h3FFF,16'hFFFF, 1,16'h0001),
               oo(1,0,14'h3FFF,16'hFFFF, 0,0,1,0, 16'h0001)};
    tbl[14] = {ii(0,0,14'h0000,16'h0000, 0,0,14'h0000,16'h0000, 0,16'h0000),
               oo(0,0,14'h0000,16'h0000, 0,0,0,0, 16'h0000)};

    // Reset: outputs quiet even with requests and ack present.
    rst_n = 1'b0;
    v = ii(1,1,14'h1111,16'h2222, 1,1,14'h3333,16'h4444, 1,16'h7777);
    drive(v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", sample(), oo(0,0,14'h0000,16'h0000, 0,0,0,0, 16'h7777));
    @(posedge clk);
    #1;
    drive('0);
    rst_n = 1'b1;
    mdl_reset();

    for (int k = 0; k < 15; k++) begin
      cycle(tbl[k].i, got, exp);
      check($sformatf("table[%0d]", k), got, tbl[k].o);
    end

    // Timeout: slave never answers m1.
    v = '0;
    v.m1_cyc = 1'b1; v.m1_write = 1'b1; v.m1_addr = 14'h0123; v.m1_wrdata = 16'hAAAA;
    busy = 0; errs = 0; err_pos = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(v, got, exp);
      check($sformatf("timeout c%0d", k), got, exp);
      if (got.bus_cyc) busy++;
      if (got.m1_err) begin
        errs++;
        err_pos = busy;
        v.m1_cyc = 1'b0;
      end
    end
    check_int("timeout busy cycles", busy, TO);
    check_int("timeout err pulses", errs, 1);
    check_int("timeout err position", err_pos, TO);

    // Ack lands in the timeout cycle: ack wins.
    v = '0;
    v.m1_cyc = 1'b1; v.m1_addr = 14'h0321; v.bus_rddata = 16'h6789;
    for (int k = 0; k < 8; k++) begin
      v.bus_ack = (k == TO);
      cycle(v, got, exp);
      check($sformatf("ack-at-timeout c%0d", k), got, exp);
      if (k == TO) begin
        check_int("ack-at-timeout m1_ack", int'(got.m1_ack), 1);
        check_int("ack-at-timeout m1_err", int'(got.m1_err), 0);
        v.m1_cyc = 1'b0;
      end
    end

    // Abort: m0 drops cyc in its second BUSY cycle.
    v = '0;
    v.m0_cyc = 1'b1; v.m0_addr = 14'h0044;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) v.m0_cyc = 1'b0;
      cycle(v, got, exp);
      check($sformatf("abort c%0d", k), got, exp);
      if (k == 2) begin
        check_int("abort bus_cyc", int'(got.bus_cyc), 0);
        check_int("abort ack/err", int'({got.m0_ack, got.m0_err, got.m1_ack, got.m1_err}), 0);
      end
    end

    // Complete an m0 transfer so that m1 would win the next tie without a reset.
    v = '0;
    v.m0_cyc = 1'b1; v.m0_addr = 14'h0055;
    cycle(v, got, exp);
    check("m0 xfer c0", got, exp);
    v.bus_ack = 1'b1;
    cycle(v, got, exp);
    check("m0 xfer c1", got, exp);
    check_int("m0 xfer ack", int'(got.m0_ack), 1);

    // Reset asserted in the middle of an m1 transfer.
    v = '0;
    v.m1_cyc = 1'b1; v.m1_addr = 14'h0066;
    cycle(v, got, exp);
    check("pre-reset c0", got, exp);
    drive(v);
    @(negedge clk);
    check_int("pre-reset bus_cyc", int'(bus_cyc), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_int("reset bus_cyc async", int'(bus_cyc), 0);
    check_int("reset ack/err", int'({m0_ack, m0_err, m1_ack, m1_err}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mdl_reset();

    // Round-robin from a tie; each master re-requests one cycle after its ack.
    v = '0;
    v.m0_cyc = 1'b1; v.m0_addr = 14'h0100;
    v.m1_cyc = 1'b1; v.m1_addr = 14'h0101; v.m1_write = 1'b1; v.m1_wrdata = 16'h0F0F;
    v.bus_ack = 1'b1; v.bus_rddata = 16'hC0DE;
    for (int k = 0; k < 40 && order.size() < 8; k++) begin
      cycle(v, got, exp);
      check($sformatf("rr c%0d", k), got, exp);
      if (got.m0_ack) order.push_back(0);
      if (got.m1_ack) order.push_back(1);
      v.m0_cyc = !exp.m0_ack;
      v.m1_cyc = !exp.m1_ack;
    end
    check_int("rr transfers", order.size(), 8);
    foreach (order[i]) check_int($sformatf("rr grant %0d", i), order[i], i % 2);

    // Randomized traffic against the model.
    v = '0;
    r0 = 1'b0;
    r1 = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (!r0 && $urandom_range(0, 2) == 0) begin
        r0 = 1'b1;
        v.m0_write = 1'($urandom); v.m0_addr = AW'($urandom); v.m0_wrdata = 16'($urandom);
      end
      if (!r1 && $urandom_range(0, 2) == 0) begin
        r1 = 1'b1;
        v.m1_write = 1'($urandom); v.m1_addr = AW'($urandom); v.m1_wrdata = 16'($urandom);
      end
      v.m0_cyc = r0;
      v.m1_cyc = r1;
      v.bus_ack = ($urandom_range(0, 3) == 0);
      v.bus_rddata = 16'($urandom);
      cycle(v, got, exp);
      check($sformatf("random c%0d", k), got, exp);
      if (exp.m0_ack || exp.m0_err || $urandom_range(0, 49) == 0) r0 = 1'b0;
      if (exp.m1_ack || exp.m1_err || $urandom_range(0, 49) == 0) r1 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
